// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the integer register file write port: merges in-order
// pipeline results with buffered load results, with anti-starvation for loads.
module regfile_wb_arbiter #(
    parameter int unsigned LD_DEPTH   = 4,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_valid,
    input  logic [4:0]  pipe_rd,
    input  logic [31:0] pipe_data,
    output logic        pipe_stall,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [4:0]  ld_rd,
    input  logic [31:0] ld_data,
    output logic        reg_wrW,
    output logic [4:0]  waddr,
    output logic [31:0] wdata,
    output logic [31:0] pend_mask
);

    localparam int unsigned PW = $clog2(LD_DEPTH);
    localparam int unsigned SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [SW-1:0] STARVE_ONE = SW'(1);
    localparam logic [PW:0]   PTR_ONE    = (PW+1)'(1);

    logic [4:0]    fifo_rd_q   [LD_DEPTH];
    logic [31:0]   fifo_data_q [LD_DEPTH];
    logic          valid_q     [LD_DEPTH];
    logic          valid_d     [LD_DEPTH];

    logic [PW:0]   wr_ptr_q, wr_ptr_d;
    logic [PW:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_idx, rd_idx;
    logic [SW-1:0] starve_q, starve_d;
    logic          out_en_q;

    logic          reg_wrW_q, reg_wrW_d;
    logic [4:0]    waddr_q, waddr_d;
    logic [31:0]   wdata_q, wdata_d;

    logic          empty, full, accept, push, pop;
    logic          pipe_wants;
    logic [4:0]    head_rd;
    logic [31:0]   head_data;

    assign wr_idx    = wr_ptr_q[PW-1:0];
    assign rd_idx    = rd_ptr_q[PW-1:0];
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_idx == rd_idx);
    assign head_rd   = fifo_rd_q[rd_idx];
    assign head_data = fifo_data_q[rd_idx];

    // out_en_q keeps ld_ready low throughout reset without routing rst into logic.
    assign ld_ready   = out_en_q && !full;
    assign accept     = ld_valid && ld_ready;
    assign push       = accept && (ld_rd != 5'd0);
    assign pipe_stall = !empty && (starve_q == STARVE_LIM);
    assign pipe_wants = pipe_valid && (pipe_rd != 5'd0);

    assign reg_wrW = reg_wrW_q;
    assign waddr   = waddr_q;
    assign wdata   = wdata_q;

    always_comb begin
        pop       = 1'b0;
        reg_wrW_d = 1'b0;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        if (pipe_stall) begin
            pop       = 1'b1;
            reg_wrW_d = 1'b1;
            waddr_d   = head_rd;
            wdata_d   = head_data;
        end else if (pipe_wants) begin
            reg_wrW_d = 1'b1;
            waddr_d   = pipe_rd;
            wdata_d   = pipe_data;
        end else if (!empty) begin
            pop       = 1'b1;
            reg_wrW_d = 1'b1;
            waddr_d   = head_rd;
            wdata_d   = head_data;
        end
    end

    always_comb begin
        wr_ptr_d = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        if (empty || pop) begin
            starve_d = '0;
        end else if (starve_q != STARVE_LIM) begin
            starve_d = starve_q + STARVE_ONE;
        end else begin
            starve_d = starve_q;
        end
    end

    // Push and pop never target the same slot: that would need a FIFO both empty and full.
    always_comb begin
        for (int unsigned i = 0; i < LD_DEPTH; i++) begin
            valid_d[i] = valid_q[i];
        end
        if (push) valid_d[wr_idx] = 1'b1;
        if (pop)  valid_d[rd_idx] = 1'b0;
    end

    always_comb begin
        pend_mask = '0;
        for (int unsigned i = 0; i < LD_DEPTH; i++) begin
            if (valid_q[i]) pend_mask[fifo_rd_q[i]] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            starve_q  <= '0;
            out_en_q  <= 1'b0;
            reg_wrW_q <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            for (int unsigned i = 0; i < LD_DEPTH; i++) begin
                valid_q[i] <= 1'b0;
            end
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            starve_q  <= starve_d;
            out_en_q  <= 1'b1;
            reg_wrW_q <= reg_wrW_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            for (int unsigned i = 0; i < LD_DEPTH; i++) begin
                valid_q[i] <= valid_d[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd_q[wr_idx]   <= ld_rd;
            fifo_data_q[wr_idx] <= ld_data;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: inputs change and outputs are checked
// 1 ns after each rising edge, so each check window is one whole cycle.
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        pipe_valid;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_data;
    logic        pipe_stall;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic        reg_wrW;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] pend_mask;

    int vectors;
    int miscompares;

    regfile_wb_arbiter #(.LD_DEPTH(4), .STARVE_MAX(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .pipe_valid (pipe_valid),
        .pipe_rd    (pipe_rd),
        .pipe_data  (pipe_data),
        .pipe_stall (pipe_stall),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_rd      (ld_rd),
        .ld_data    (ld_data),
        .reg_wrW    (reg_wrW),
        .waddr      (waddr),
        .wdata      (wdata),
        .pend_mask  (pend_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pipe(input logic v, input logic [4:0] rd, input logic [31:0] d);
        pipe_valid = v;
        pipe_rd    = rd;
        pipe_data  = d;
    endtask

    task automatic set_ld(input logic v, input logic [4:0] rd, input logic [31:0] d);
        ld_valid = v;
        ld_rd    = rd;
        ld_data  = d;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        set_pipe(1'b0, 5'd0, 32'd0);
        set_ld(1'b0, 5'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (reg_wrW !== 1'b0) begin miscompares++; $display("FAIL rst_wrW: got %0h want 0", reg_wrW); end
        vectors++; if (waddr !== 5'd0) begin miscompares++; $display("FAIL rst_waddr: got %0h want 0", waddr); end
        vectors++; if (wdata !== 32'd0) begin miscompares++; $display("FAIL rst_wdata: got %0h want 0", wdata); end
        vectors++; if (pend_mask !== 32'd0) begin miscompares++; $display("FAIL rst_mask: got %0h want 0", pend_mask); end
        vectors++; if (pipe_stall !== 1'b0) begin miscompares++; $display("FAIL rst_stall: got %0h want 0", pipe_stall); end
        vectors++; if (ld_ready !== 1'b0) begin miscompares++; $display("FAIL rst_ready: got %0h want 0", ld_ready); end
        @(negedge clk);
        rst = 1'b1;
        tick();
        vectors++; if (ld_ready !== 1'b1) begin miscompares++; $display("FAIL rel_ready: got %0h want 1", ld_ready); end
    endtask

    task automatic test_pipeline();
        set_pipe(1'b1, 5'd5, 32'hDEADBEEF);
        tick();
        vectors++; if (reg_wrW !== 1'b1) begin miscompares++; $display("FAIL pipe_wrW: got %0h want 1", reg_wrW); end
        vectors++; if (waddr !== 5'd5) begin miscompares++; $display("FAIL pipe_waddr: got %0h want 5", waddr); end
        vectors++; if (wdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL pipe_wdata: got %0h want deadbeef", wdata); end
        set_pipe(1'b1, 5'd0, 32'h12345678);
        tick();
        vectors++; if (reg_wrW !== 1'b0) begin miscompares++; $display("FAIL pipe_x0_wrW: got %0h want 0", reg_wrW); end
        vectors++; if (wdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL pipe_hold_wdata: got %0h want deadbeef", wdata); end
        set_pipe(1'b0, 5'd0, 32'd0);
        tick();
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 4; i++) begin
            set_pipe(1'b1, 5'(i + 20), 32'(i * 32'h1010));
            tick();
            vectors++; if (reg_wrW !== 1'b1 || waddr !== 5'(i + 20) || wdata !== 32'(i * 32'h1010)) begin
                miscompares++; $display("FAIL b2b_%0d: got %0h/%0h/%0h want 1/%0h/%0h", i, reg_wrW, waddr, wdata, 5'(i + 20), 32'(i * 32'h1010));
            end
        end
        set_pipe(1'b0, 5'd0, 32'd0);
        tick();
        vectors++; if (reg_wrW !== 1'b0) begin miscompares++; $display("FAIL b2b_idle: got %0h want 0", reg_wrW); end
    endtask

    task automatic test_load_buffering();
        set_pipe(1'b1, 5'd1, 32'hA1);
        set_ld(1'b1, 5'd3, 32'h11);
        vectors++; if (ld_ready !== 1'b1) begin miscompares++; $display("FAIL buf_ready: got %0h want 1", ld_ready); end
        tick();
        vectors++; if (pend_mask !== 32'h08) begin miscompares++; $display("FAIL buf_mask1: got %0h want 8", pend_mask); end
        set_ld(1'b1, 5'd4, 32'h22);
        tick();
        vectors++; if (pend_mask !== 32'h18) begin miscompares++; $display("FAIL buf_mask2: got %0h want 18", pend_mask); end
        set_ld(1'b1, 5'd3, 32'h33);
        tick();
        vectors++; if (pend_mask !== 32'h18) begin miscompares++; $display("FAIL buf_mask3: got %0h want 18", pend_mask); end
        set_ld(1'b0, 5'd0, 32'd0);
        set_pipe(1'b0, 5'd0, 32'd0);
        tick();
        vectors++; if (reg_wrW !== 1'b1 || waddr !== 5'd3 || wdata !== 32'h11) begin miscompares++; $display("FAIL buf_w1: got %0h/%0h/%0h want 1/3/11", reg_wrW, waddr, wdata); end
        vectors++; if (pend_mask !== 32'h18) begin miscompares++; $display("FAIL buf_mask4: got %0h want 18", pend_mask); end
        tick();
        vectors++; if (reg_wrW !== 1'b1 || waddr !== 5'd4 || wdata !== 32'h22) begin miscompares++; $display("FAIL buf_w2: got %0h/%0h/%0h want 1/4/22", reg_wrW, waddr, wdata); end
        vectors++; if (pend_mask !== 32'h08) begin miscompares++; $display("FAIL buf_mask5: got %0h want 8", pend_mask); end
        tick();
        vectors++; if (reg_wrW !== 1'b1 || waddr !== 5'd3 || wdata !== 32'h33) begin miscompares++; $display("FAIL buf_w3: got %0h/%0h/%0h want 1/3/33", reg_wrW, waddr, wdata); end
        vectors++; if (pend_mask !== 32'h0) begin miscompares++; $display("FAIL buf_mask6: got %0h want 0", pend_mask); end
        tick();
        vectors++; if (reg_wrW !== 1'b0) begin miscompares++; $display("FAIL buf_idle: got %0h want 0", reg_wrW); end
    endtask

    task automatic test_full_fifo();
        set_pipe(1'b1, 5'd1, 32'hB0);
        for (int c = 0; c < 4; c++) begin
            set_ld(1'b1, 5'(10 + c), 32'(32'h100 * (c + 1)));
            vectors++; if (ld_ready !== 1'b1) begin miscompares++; $display("FAIL full_ready_c%0d: got %0h want 1", c, ld_ready); end
            tick();
        end
        vectors++; if (reg_wrW !== 1'b1 || waddr !== 5'd1) begin miscompares++; $display("FAIL full_pipewr: got %0h/%0h want 1/1", reg_wrW, waddr); end
        set_ld(1'b1, 5'd14, 32'h500);
        for (int c = 4; c <= 9; c++) begin
            vectors++; if (ld_ready !== 1'b0) begin miscompares++; $display("FAIL full_notready_c%0d: got %0h want 0", c, ld_ready); end
            vectors++; if (pipe_stall !== (c == 9)) begin miscompares++; $display("FAIL full_stall_c%0d: got %0h want %0h", c, pipe_stall, (c == 9)); end
            tick();
        end
        vectors++; if (ld_ready !== 1'b1) begin miscompares++; $display("FAIL full_reaccept: got %0h want 1", ld_ready); end
        vectors++; if (reg_wrW !== 1'b1 || waddr !== 5'd10 || wdata !== 32'h100) begin miscompares++; $display("FAIL full_pop1: got %0h/%0h/%0h want 1/a/100", reg_wrW, waddr, wdata); end
        tick();
        set_ld(1'b0, 5'd0, 32'd0);
        set_pipe(1'b0, 5'd0, 32'd0);
        vectors++; if (reg_wrW !== 1'b1 || waddr !== 5'd1) begin miscompares++; $display("FAIL full_heldpipe: got %0h/%0h want 1/1", reg_wrW, waddr); end
        vectors++; if (pend_mask !== 32'h7800) begin miscompares++; $display("FAIL full_mask: got %0h want 7800", pend_mask); end
        tick();
        for (int c = 1; c <= 4; c++) begin
            vectors++; if (reg_wrW !== 1'b1 || waddr !== 5'(10 + c) || wdata !== 32'(32'h100 * (c + 1))) begin
                miscompares++; $display("FAIL full_drain_%0d: got %0h/%0h/%0h want 1/%0h/%0h", c, reg_wrW, waddr, wdata, 5'(10 + c), 32'(32'h100 * (c + 1)));
            end
            tick();
        end
        vectors++; if (reg_wrW !== 1'b0 || pend_mask !== 32'h0) begin miscompares++; $display("FAIL full_empty: got %0h/%0h want 0/0", reg_wrW, pend_mask); end
    endtask

    task automatic test_starvation();
        int stalls;
        stalls = 0;
        set_pipe(1'b1, 5'd7, 32'h77);
        set_ld(1'b1, 5'd9, 32'h99);
        tick();
        set_ld(1'b0, 5'd0, 32'd0);
        for (int c = 1; c <= 11; c++) begin
            if (pipe_stall === 1'b1) stalls++;
            vectors++; if (pipe_stall !== (c == 9)) begin miscompares++; $display("FAIL starve_stall_c%0d: got %0h want %0h", c, pipe_stall, (c == 9)); end
            if (c <= 9) begin
                vectors++; if (pend_mask !== 32'h200) begin miscompares++; $display("FAIL starve_mask_c%0d: got %0h want 200", c, pend_mask); end
            end
            if (c == 10) begin
                vectors++; if (reg_wrW !== 1'b1 || waddr !== 5'd9 || wdata !== 32'h99) begin miscompares++; $display("FAIL starve_ldwr: got %0h/%0h/%0h want 1/9/99", reg_wrW, waddr, wdata); end
            end else begin
                vectors++; if (reg_wrW !== 1'b1 || waddr !== 5'd7 || wdata !== 32'h77) begin miscompares++; $display("FAIL starve_pipewr_c%0d: got %0h/%0h/%0h want 1/7/77", c, reg_wrW, waddr, wdata); end
            end
            tick();
        end
        vectors++; if (stalls != 1) begin miscompares++; $display("FAIL starve_count: got %0d want 1", stalls); end
        set_pipe(1'b0, 5'd0, 32'd0);
        tick();
        tick();
    endtask

    task automatic test_slot_sharing();
        set_pipe(1'b1, 5'd0, 32'hAA);
        set_ld(1'b1, 5'd12, 32'hC0);
        tick();
        set_ld(1'b0, 5'd0, 32'd0);
        vectors++; if (reg_wrW !== 1'b0) begin miscompares++; $display("FAIL share_x0pipe: got %0h want 0", reg_wrW); end
        vectors++; if (pend_mask !== 32'h1000) begin miscompares++; $display("FAIL share_mask: got %0h want 1000", pend_mask); end
        tick();
        vectors++; if (reg_wrW !== 1'b1 || waddr !== 5'd12 || wdata !== 32'hC0) begin miscompares++; $display("FAIL share_wr: got %0h/%0h/%0h want 1/c/c0", reg_wrW, waddr, wdata); end
        set_pipe(1'b0, 5'd0, 32'd0);
        set_ld(1'b1, 5'd0, 32'hFF);
        vectors++; if (ld_ready !== 1'b1) begin miscompares++; $display("FAIL x0ld_ready: got %0h want 1", ld_ready); end
        tick();
        set_ld(1'b0, 5'd0, 32'd0);
        vectors++; if (pend_mask !== 32'h0 || reg_wrW !== 1'b0) begin miscompares++; $display("FAIL x0ld_a: got %0h/%0h want 0/0", pend_mask, reg_wrW); end
        tick();
        vectors++; if (pend_mask !== 32'h0 || reg_wrW !== 1'b0) begin miscompares++; $display("FAIL x0ld_b: got %0h/%0h want 0/0", pend_mask, reg_wrW); end
    endtask

    task automatic test_reset_midstream();
        set_pipe(1'b1, 5'd1, 32'hE1);
        for (int c = 0; c < 3; c++) begin
            set_ld(1'b1, 5'(2 + c), 32'(c + 2));
            tick();
        end
        set_ld(1'b0, 5'd0, 32'd0);
        vectors++; if (pend_mask !== 32'h1C) begin miscompares++; $display("FAIL mid_mask: got %0h want 1c", pend_mask); end
        vectors++; if (reg_wrW !== 1'b1 || waddr !== 5'd1) begin miscompares++; $display("FAIL mid_pre: got %0h/%0h want 1/1", reg_wrW, waddr); end
        #2;
        rst = 1'b0;
        #1;
        vectors++; if (reg_wrW !== 1'b0 || waddr !== 5'd0 || wdata !== 32'd0) begin miscompares++; $display("FAIL mid_out: got %0h/%0h/%0h want 0/0/0", reg_wrW, waddr, wdata); end
        vectors++; if (pend_mask !== 32'd0 || pipe_stall !== 1'b0 || ld_ready !== 1'b0) begin
            miscompares++; $display("FAIL mid_flags: got %0h/%0h/%0h want 0/0/0", pend_mask, pipe_stall, ld_ready);
        end
        set_pipe(1'b0, 5'd0, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            vectors++; if (ld_ready !== 1'b1 || pend_mask !== 32'd0 || reg_wrW !== 1'b0) begin
                miscompares++; $display("FAIL mid_after_%0d: got %0h/%0h/%0h want 1/0/0", c, ld_ready, pend_mask, reg_wrW);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_pipeline();
        test_back_to_back();
        test_load_buffering();
        test_full_fifo();
        test_starvation();
        test_slot_sharing();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
